// File: rtl/bcd2binary.sv
// Sequential BCD-to-binary converter using reverse double-dabble:
// one right shift per clock, digits >= 8 corrected by -3 after each shift.
module bcd2binary #(
    parameter int unsigned NDIGITS = 4,
    parameter int unsigned BIN_W   = 14
) (
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic [4*NDIGITS-1:0]   bcd_in,
    output logic                   busy,
    output logic                   done,
    output logic [BIN_W-1:0]       bin_out,
    output logic                   err
);

    localparam int unsigned BCD_W = 4 * NDIGITS;
    localparam int unsigned CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [BCD_W-1:0] bcd_q, bcd_d;
    logic [BIN_W-1:0] bin_q, bin_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_r_q, err_r_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [BIN_W-1:0] bin_out_q, bin_out_d;
    logic             err_q, err_d;

    logic [BCD_W-1:0] bcd_shift;
    logic [BCD_W-1:0] bcd_corr;
    logic [BIN_W-1:0] bin_shift;
    logic             in_err;

    always_comb begin
        bcd_shift = {1'b0, bcd_q[BCD_W-1:1]};
        bin_shift = {bcd_q[0], bin_q[BIN_W-1:1]};
        bcd_corr  = bcd_shift;
        // A digit is >= 8 exactly when its top bit is set.
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (bcd_shift[4*i+3]) begin
                bcd_corr[4*i +: 4] = bcd_shift[4*i +: 4] - 4'd3;
            end
        end
        in_err = 1'b0;
        for (int unsigned i = 0; i < NDIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) begin
                in_err = 1'b1;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        bcd_d     = bcd_q;
        bin_d     = bin_q;
        cnt_d     = cnt_q;
        err_r_d   = err_r_q;
        busy_d    = busy_q;
        done_d    = done_q;
        bin_out_d = bin_out_q;
        err_d     = err_q;
        case (state_q)
            ST_IDLE: begin
                done_d = 1'b0;
                if (start) begin
                    bcd_d   = bcd_in;
                    bin_d   = '0;
                    cnt_d   = '0;
                    err_r_d = in_err;
                    busy_d  = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bin_d = bin_shift;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_STEP) begin
                    bcd_d     = bcd_shift;
                    bin_out_d = err_r_q ? '0 : bin_shift;
                    err_d     = err_r_q;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    bcd_d = bcd_corr;
                end
            end
            ST_DONE: begin
                done_d  = 1'b0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= ST_IDLE;
            bcd_q     <= '0;
            bin_q     <= '0;
            cnt_q     <= '0;
            err_r_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bin_out_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bcd_q     <= bcd_d;
            bin_q     <= bin_d;
            cnt_q     <= cnt_d;
            err_r_q   <= err_r_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            bin_out_q <= bin_out_d;
            err_q     <= err_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bin_out = bin_out_q;
    assign err     = err_q;

endmodule

// File: tb/tb_bcd2binary.sv
// Self-checking bench for bcd2binary: vector table, corner-case sequences
// and random conversions checked against a decimal-arithmetic reference.
module tb_bcd2binary;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic [15:0] bcd_in;
    logic        busy;
    logic        done;
    logic [13:0] bin_out;
    logic        err;

    int total;
    int bad;
    int done_cnt;
    logic prev_done;
    logic [13:0] last_bin;
    logic last_err;

    bcd2binary #(.NDIGITS(4), .BIN_W(14)) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .bin_out (bin_out),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // done must be a single-cycle pulse and always inside busy.
    initial prev_done = 1'b0;
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_cnt++;
            chk("done_inside_busy", {31'd0, busy}, 32'd1);
            chk("done_one_cycle", {31'd0, prev_done}, 32'd0);
        end
        prev_done = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Decimal reference: weigh each nibble by its power of ten.
    task automatic ref_model(input logic [15:0] v, output logic [13:0] b, output logic e);
        int val;
        int dig;
        val = 0;
        e = 1'b0;
        for (int d = 3; d >= 0; d--) begin
            dig = int'((v >> (4 * d)) & 16'hF);
            if (dig > 9) e = 1'b1;
            val = val * 10 + dig;
        end
        b = e ? 14'd0 : 14'(val);
    endtask

    task automatic do_start(input logic [15:0] v);
        bcd_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        bcd_in = 16'($urandom);
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            chk("bin_out_stable", {18'd0, bin_out}, {18'd0, last_bin});
            chk("err_stable", {31'd0, err}, {31'd0, last_err});
            tick();
            lat++;
        end
        if (lat >= 40) chk("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic convert(input logic [15:0] v, input logic [13:0] eb, input logic ee, input string nm);
        int lat;
        do_start(v);
        wait_done(lat);
        chk({nm, "_latency"}, lat, 32'd14);
        chk({nm, "_bin"}, {18'd0, bin_out}, {18'd0, eb});
        chk({nm, "_err"}, {31'd0, err}, {31'd0, ee});
        last_bin = eb;
        last_err = ee;
        tick();
        chk({nm, "_done_clr"}, {31'd0, done}, 32'd0);
        chk({nm, "_busy_clr"}, {31'd0, busy}, 32'd0);
    endtask

    typedef struct {
        logic [15:0] bcd;
        logic [13:0] bin;
        logic        e;
        string       nm;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int lat;
        int dc0;
        logic [13:0] mb;
        logic me;
        logic [15:0] v;
        int n;

        vecs[0]  = '{16'h0000, 14'd0,    1'b0, "zero"};
        vecs[1]  = '{16'h1234, 14'd1234, 1'b0, "v1234"};
        vecs[2]  = '{16'h9999, 14'd9999, 1'b0, "max9999"};
        vecs[3]  = '{16'h0008, 14'd8,    1'b0, "v8"};
        vecs[4]  = '{16'h0010, 14'd10,   1'b0, "v10"};
        vecs[5]  = '{16'h0A00, 14'd0,    1'b1, "badA"};
        vecs[6]  = '{16'h0042, 14'd42,   1'b0, "after_bad"};
        vecs[7]  = '{16'hF000, 14'd0,    1'b1, "badF"};
        vecs[8]  = '{16'h0009, 14'd9,    1'b0, "v9"};
        vecs[9]  = '{16'h0090, 14'd90,   1'b0, "v90"};
        vecs[10] = '{16'h0801, 14'd801,  1'b0, "v801"};

        total = 0;
        bad = 0;
        done_cnt = 0;
        last_bin = 14'd0;
        last_err = 1'b0;
        n_rst = 1'b0;
        start = 1'b0;
        bcd_in = 16'h0000;

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_bin", {18'd0, bin_out}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        tick();
        n_rst = 1'b1;
        tick();

        for (int i = 0; i < 11; i++) begin
            convert(vecs[i].bcd, vecs[i].bin, vecs[i].e, vecs[i].nm);
        end

        // start pulsed mid-conversion is ignored
        dc0 = done_cnt;
        do_start(16'h0321);
        repeat (4) tick();
        bcd_in = 16'h0777;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(lat);
        chk("midstart_latency", lat, 32'd9);
        chk("midstart_bin", {18'd0, bin_out}, 32'd321);
        last_bin = 14'd321;
        last_err = 1'b0;
        repeat (3) tick();
        chk("midstart_one_done", done_cnt, dc0 + 1);
        chk("midstart_idle", {31'd0, busy}, 32'd0);

        // reset in the middle of a conversion
        do_start(16'h1234);
        repeat (5) tick();
        dc0 = done_cnt;
        #3 n_rst = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_done", {31'd0, done}, 32'd0);
        chk("abort_bin", {18'd0, bin_out}, 32'd0);
        chk("abort_err", {31'd0, err}, 32'd0);
        repeat (20) tick();
        chk("abort_no_done", done_cnt, dc0);
        n_rst = 1'b1;
        last_bin = 14'd0;
        last_err = 1'b0;
        tick();
        convert(16'h0500, 14'd500, 1'b0, "after_abort");

        // start held high re-triggers every BIN_W+2 cycles
        bcd_in = 16'h0123;
        start = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            wait_done(lat);
            chk("hold_latency", lat, 32'd14);
            chk("hold_bin", {18'd0, bin_out}, 32'd123);
            chk("hold_err", {31'd0, err}, 32'd0);
            last_bin = 14'd123;
            last_err = 1'b0;
            if (k == 2) start = 1'b0;
            tick();
            chk("hold_idle_gap", {31'd0, busy}, 32'd0);
            tick();
            chk("hold_rearm", {31'd0, busy}, (k == 2) ? 32'd0 : 32'd1);
        end

        // random conversions against the decimal reference
        for (int r = 0; r < 60; r++) begin
            n = int'($urandom_range(0, 9999));
            v = 16'd0;
            for (int d = 0; d < 4; d++) begin
                v = v | (16'((n / (10 ** d)) % 10) << (4 * d));
            end
            if ($urandom_range(0, 7) == 0) begin
                v = v | (16'(10 + $urandom_range(0, 5)) << (4 * $urandom_range(0, 3)));
            end
            ref_model(v, mb, me);
            convert(v, mb, me, "random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
